gamma_replay_buffer_nch: RTL
============================

// Module: gamma_replay_buffer_nch
// PURPOSE
//  Ping-pong spike replay buffer with NUM_CH input channels per lane (previous generation fixed at 2).
//  Captures one gamma window of spikes per channel into the write bank.
//  During the next window, replays the captured bank one channel at a time onto a single P-wide bus.
//  Compresses NUM_CH samples into one output cycle. Sits between the input spike sources and the
//  multiplexed column.
// PARAMETERS
//  P        64  lanes (spike lines per channel)
//  NUM_CH   2   input channels time-multiplexed onto dout; power of 2, >=2
//  DEPTH    16  samples stored per gamma window per channel; DEPTH % NUM_CH == 0
//  (derived) SLOT = DEPTH/NUM_CH  replay cycles per channel
// PORTS
//  clk          in   1           clock
//  grst         in   1           reset, asynchronous, active-high
//  gamma_start  in   1           sync pulse; the cycle it is high is sample 0 of a new window
//  din          in   NUM_CH*P    channel c occupies din[c*P +: P]
//  dout         out  P           replayed/compressed spikes, registered
//  dout_valid   out  1           dout carries replay data
//  dout_ch      out  clog2(NUM_CH)  channel currently replayed
//  overflow     out  1           sticky: a window exceeded DEPTH samples
// BEHAVIOUR
//  Reset (grst=1, async): state IDLE; dout=0, dout_valid=0, dout_ch=0, overflow=0.
//   Write/read indices = 0; bank_w = 0; fill counts of both banks = 0. Memory contents are not cleared.
//  State machine:
//   IDLE: gamma_start -> FILL.
//   FILL: captures window 0, no replay; gamma_start -> RUN.
//   RUN: captures and replays simultaneously; stays in RUN.
//  Capture: each cycle in FILL/RUN (incl. the gamma_start cycle), writes din into bank_w at wr_idx.
//   wr_idx increments and saturates at DEPTH.
//   Writes with wr_idx==DEPTH are dropped and set overflow (cleared by grst only).
//  Swap, on gamma_start in FILL/RUN:
//   fill[bank_w] <= wr_idx; bank_w toggles; the current-cycle sample goes to index 0 of the new bank_w.
//   Read bank = previous bank_w. Replay counter r <= 0.
//  Replay (RUN), registered, 1-cycle latency: gamma_start at cycle t gives r=0 on dout at t+1.
//   r = t+1..t+DEPTH.
//   ch = r / SLOT, k = r % SLOT; dout_ch = ch.
//   dout = OR over j=0..NUM_CH-1 of mem[rd_bank][ch][k*NUM_CH+j].
//   Any index >= fill[rd_bank] reads as 0 (stale data never replayed).
//  dout_valid=1 while r < DEPTH.
//   After DEPTH replay cycles: dout_valid=0, dout=0, dout_ch holds; waits for next gamma_start.
//  Short window (gamma_start before DEPTH samples): the replay in progress is truncated.
//   New replay restarts at r=0 from the just-filled bank; no output glitch, dout_valid stays 1.
//  Long window (>DEPTH samples): overflow=1; replay uses samples 0..DEPTH-1 only.
//  gamma_start in IDLE: no replay; only the first window starts capture.
//  Consecutive gamma_start on back-to-back cycles: each swaps; a bank of fill=1 replays sample 0 only.
//  Reset mid-operation: immediate return to IDLE; the first post-reset window is never replayed.
// CONFIGURATION
//  RB_OR_COMPRESS_EN defined:
//   dout = OR of NUM_CH consecutive samples (no spike lost in compression).
//  Not defined:
//   pure decimation, dout = mem[rd_bank][ch][k*NUM_CH] (sample j=0 only).
//   Fill-gating and all timing are identical.
// TESTING  (P=4, NUM_CH=2, DEPTH=8, SLOT=4; gamma_start at t0 and t1=t0+8)
//  1. Reset: grst pulse mid-clock -> dout=0, dout_valid=0, dout_ch=0, overflow=0 before next clk edge.
//  2. Window 0: ch0 lane0=1 at sample 3 only, all else 0.
//     -> t1+1..t1+8: dout_valid=1; dout_ch=0 for t1+1..t1+4 and 1 for t1+5..t1+8.
//     -> dout=4'b0001 at t1+2 with RB_OR_COMPRESS_EN.
//     -> dout=0 everywhere without RB_OR_COMPRESS_EN.
//  3. Short window: prior window all-ones, then gamma_start 5 samples later (fill=5), all samples 1.
//     -> ch0 k=2 gives 4'b1111 (idx 4 valid), ch0 k=3 gives 0 (idx 6,7 gated).
//  4. Long window: 11 samples between gamma_starts.
//     -> overflow=1 from the 9th write, stays 1.
//     -> replay shows samples 0..7 only; dout_valid=0 at r>=8 until the next gamma_start.
//  5. Truncation: gamma_start 3 cycles into a replay.
//     -> next cycle r=0 from the new bank; dout_valid stays 1 with no gap.
//  6. grst asserted in RUN at t1+3, released 2 cycles later.
//     -> IDLE; next gamma_start gives no replay; the one after it gives replay.

Source files
------------

// File: rtl/gamma_replay_buffer_nch.sv
// gamma_replay_buffer_nch
// Ping-pong spike replay buffer. One gamma window of NUM_CH x P spike lines is
// captured into the write bank while the previously captured bank is replayed
// one channel at a time onto a single P-wide bus. Each output cycle folds
// NUM_CH consecutive samples of a channel together.
// Optional feature macro: RB_OR_COMPRESS_EN
//   defined     : dout is the OR of the NUM_CH folded samples (no spike lost)
//   not defined : pure decimation, only the first sample of each group is kept
module gamma_replay_buffer_nch #(
   parameter int P      = 64,
   parameter int NUM_CH = 2,
   parameter int DEPTH  = 16
) (
   input  logic                      clk,
   input  logic                      grst,
   input  logic                      gamma_start,
   input  logic [NUM_CH*P-1:0]       din,
   output logic [P-1:0]              dout,
   output logic                      dout_valid,
   output logic [$clog2(NUM_CH)-1:0] dout_ch,
   output logic                      overflow
);

   localparam int SLOT = DEPTH / NUM_CH;
   localparam int CW   = $clog2(DEPTH + 1);
   localparam int IW   = $clog2(DEPTH);
   localparam int CHW  = $clog2(NUM_CH);
`ifdef RB_OR_COMPRESS_EN
   localparam int NJ   = NUM_CH;
`else
   localparam int NJ   = 1;
`endif
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      RUN
   } state_t;

   state_t         state;
   logic [CW-1:0]  wr_idx;
   logic [CW-1:0]  rep_idx;
   logic           bank_w;
   logic           rd_bank;
   logic [CW-1:0]  fill [2];
   logic [P-1:0]   mem [2][NUM_CH][DEPTH];

   logic           swap;
   logic           capture;
   logic           wr_bank;
   logic [CW-1:0]  wr_pos;
   logic [IW-1:0]  wr_addr;
   logic           wr_en;
   logic           sel_bank;
   logic [CW-1:0]  sel_r;
   logic [CW-1:0]  sel_fill;
   logic           replay_now;
   logic [P-1:0]   rd_data;
   logic [CHW-1:0] rd_ch;
   int             r_i;
   int             ch_i;
   int             k_i;
   int             idx_i;

   // Capture side: the gamma_start sample always lands at index 0, and in
   // FILL/RUN it lands in the bank we are about to switch to.
   always_comb begin
      swap    = gamma_start && (state != IDLE);
      capture = gamma_start || (state != IDLE);
      wr_bank = swap ? ~bank_w : bank_w;
      wr_pos  = gamma_start ? '0 : wr_idx;
      wr_addr = wr_pos[IW-1:0];
      wr_en   = capture && (wr_pos != DEPTH_C);
   end

   // Replay source select: on a swap the just-closed write bank is replayed
   // immediately from r=0, using the live write count as its fill level.
   always_comb begin
      sel_bank   = swap ? bank_w : rd_bank;
      sel_r      = swap ? '0 : rep_idx;
      sel_fill   = swap ? wr_idx : fill[rd_bank];
      replay_now = swap || ((state == RUN) && (rep_idx < DEPTH_C));
   end

   // Fold NUM_CH consecutive samples of the current channel into one word,
   // reading anything at or beyond the bank's fill level as zero.
   always_comb begin
      rd_data = '0;
      rd_ch   = '0;
      r_i     = int'(sel_r);
      ch_i    = 0;
      k_i     = 0;
      idx_i   = 0;
      if (r_i < DEPTH) begin
         ch_i  = r_i / SLOT;
         k_i   = r_i % SLOT;
         rd_ch = CHW'(ch_i);
         for (int j = 0; j < NJ; j++) begin
            idx_i = k_i * NUM_CH + j;
            if (idx_i < int'(sel_fill)) begin
               rd_data = rd_data | mem[sel_bank][CHW'(ch_i)][IW'(idx_i)];
            end
         end
      end
   end

   // Sample storage; contents deliberately survive reset since fill gating
   // keeps stale entries from ever being replayed.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int c = 0; c < NUM_CH; c++) begin
            mem[wr_bank][CHW'(c)][wr_addr] <= din[c*P +: P];
         end
      end
   end

   // Control FSM with write counter, bank swap bookkeeping and registered replay outputs.
   always_ff @(posedge clk or posedge grst) begin
      if (grst) begin
         state      <= IDLE;
         wr_idx     <= '0;
         rep_idx    <= '0;
         bank_w     <= 1'b0;
         rd_bank    <= 1'b0;
         fill[0]    <= '0;
         fill[1]    <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         dout_ch    <= '0;
         overflow   <= 1'b0;
      end else begin
         case (state)
            IDLE:    if (gamma_start) state <= FILL;
            FILL:    if (gamma_start) state <= RUN;
            RUN:     state <= RUN;
            default: state <= IDLE;
         endcase

         if (capture) begin
            if (gamma_start) begin
               wr_idx <= CW'(1);
            end else if (wr_idx != DEPTH_C) begin
               wr_idx <= wr_idx + CW'(1);
            end else begin
               overflow <= 1'b1;
            end
         end

         if (swap) begin
            fill[bank_w] <= wr_idx;
            bank_w       <= ~bank_w;
            rd_bank      <= bank_w;
         end

         if (replay_now) begin
            dout       <= rd_data;
            dout_valid <= 1'b1;
            dout_ch    <= rd_ch;
            rep_idx    <= sel_r + CW'(1);
         end else begin
            dout       <= '0;
            dout_valid <= 1'b0;
         end
      end
   end

endmodule
